// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable SimpleRISC inter-stage latch with valid bit, flush/bubble insertion and ctrl squash.
// Define PIPE_PERF_CNT_EN to add saturating stall/bubble/issue counters and the cnt_clr input.
module pipe_stage_reg #(
  parameter int          DATA_W   = 128,
  parameter int          CTRL_W   = 16,
  parameter int          RSEL_W   = 15,
  parameter logic [31:0] NOP_INST = 32'h6800_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [31:0]       inst_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [RSEL_W-1:0] rsel_in,
  output logic              valid_out,
  output logic [31:0]       inst_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [RSEL_W-1:0] rsel_out
`ifdef PIPE_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  issue_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_LOAD   = 2'd2,
    ACT_BUBBLE = 2'd3
  } act_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  if (DATA_W < 1 || CTRL_W < 1 || RSEL_W < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_stage_reg: all widths must be at least 1");
  end

  act_e                act_p0;
  state_e              state_p1;
  state_e              state_nxt;
  logic [31:0]         inst_p1;
  logic [CTRL_W-1:0]   ctrl_p1;
  logic [DATA_W-1:0]   data_p1;
  logic [RSEL_W-1:0]   rsel_p1;

  // Stage p0: one action per cycle; flush outranks stall so a mispredict never gets held.
  always_comb begin
    act_p0 = ACT_BUBBLE;
    if (flush)         act_p0 = ACT_FLUSH;
    else if (stall)    act_p0 = ACT_HOLD;
    else if (valid_in) act_p0 = ACT_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= ST_EMPTY;
    else     state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (act_p0)
      ACT_LOAD:              state_nxt = ST_FULL;
      ACT_FLUSH, ACT_BUBBLE: state_nxt = ST_EMPTY;
      default:               state_nxt = state_p1;
    endcase
  end

  // Stage p1: payload latch; bubbles load a NOP with ctrl cleared so nothing downstream writes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_p1 <= NOP_INST;
      ctrl_p1 <= '0;
      data_p1 <= '0;
      rsel_p1 <= '0;
    end else begin
      case (act_p0)
        ACT_LOAD: begin
          inst_p1 <= inst_in;
          ctrl_p1 <= ctrl_in;
          data_p1 <= data_in;
          rsel_p1 <= rsel_in;
        end
        ACT_FLUSH, ACT_BUBBLE: begin
          inst_p1 <= NOP_INST;
          ctrl_p1 <= '0;
          data_p1 <= '0;
          rsel_p1 <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_out = (state_p1 == ST_FULL);
    inst_out  = inst_p1;
    ctrl_out  = ctrl_p1;
    data_out  = data_p1;
    rsel_out  = rsel_p1;
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic stall_hit_p0;
  logic bubble_hit_p0;
  logic issue_hit_p0;

  // A stall only counts when it actually holds a live instruction.
  always_comb begin
    stall_hit_p0  = (act_p0 == ACT_HOLD) && (state_p1 == ST_FULL);
    bubble_hit_p0 = (act_p0 == ACT_FLUSH) || (act_p0 == ACT_BUBBLE);
    issue_hit_p0  = (act_p0 == ACT_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      issue_cnt  <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      issue_cnt  <= '0;
    end else begin
      if (stall_hit_p0)  stall_cnt  <= sat_inc(stall_cnt);
      if (bubble_hit_p0) bubble_cnt <= sat_inc(bubble_cnt);
      if (issue_hit_p0)  issue_cnt  <= sat_inc(issue_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plan scenarios plus randomized traffic against a spec-level model.
module tb_pipe_stage_reg;

  localparam int          DW  = 128;
  localparam int          CW  = 16;
  localparam int          RW  = 15;
  localparam int          NW  = 4;
  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam int unsigned CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, valid_in;
  logic [31:0]   inst_in;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;
  logic [RW-1:0] rsel_in;
  logic          valid_out;
  logic [31:0]   inst_out;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] data_out;
  logic [RW-1:0] rsel_out;
`ifdef PIPE_PERF_CNT_EN
  logic          cnt_clr;
  logic [NW-1:0] stall_cnt, bubble_cnt, issue_cnt;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RSEL_W(RW), .NOP_INST(NOP), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .inst_in(inst_in), .ctrl_in(ctrl_in), .data_in(data_in), .rsel_in(rsel_in),
    .valid_out(valid_out), .inst_out(inst_out), .ctrl_out(ctrl_out),
    .data_out(data_out), .rsel_out(rsel_out)
`ifdef PIPE_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: what the stage should hold after each edge.
  logic          m_valid;
  logic [31:0]   m_inst;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_rsel;
  int unsigned   m_stall_c, m_bubble_c, m_issue_c;
  logic          m_clr;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_inst = NOP; m_ctrl = '0; m_data = '0; m_rsel = '0;
    m_stall_c = 0; m_bubble_c = 0; m_issue_c = 0;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_inst = NOP; m_ctrl = '0; m_data = '0; m_rsel = '0;
  endtask

  task automatic model_edge();
    bit s_inc, b_inc, i_inc;
    s_inc = stall && !flush && m_valid;
    b_inc = flush || (!stall && !valid_in);
    i_inc = !flush && !stall && valid_in;
    if (flush) model_bubble();
    else if (stall) ;
    else if (valid_in) begin
      m_valid = 1'b1; m_inst = inst_in; m_ctrl = ctrl_in; m_data = data_in; m_rsel = rsel_in;
    end else model_bubble();
    if (m_clr) begin
      m_stall_c = 0; m_bubble_c = 0; m_issue_c = 0;
    end else begin
      if (s_inc && m_stall_c  < CMAX) m_stall_c++;
      if (b_inc && m_bubble_c < CMAX) m_bubble_c++;
      if (i_inc && m_issue_c  < CMAX) m_issue_c++;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".valid"}, 128'(valid_out), 128'(m_valid));
    check_val({tag, ".inst"},  128'(inst_out),  128'(m_inst));
    check_val({tag, ".ctrl"},  128'(ctrl_out),  128'(m_ctrl));
    check_val({tag, ".data"},  128'(data_out),  128'(m_data));
    check_val({tag, ".rsel"},  128'(rsel_out),  128'(m_rsel));
    if (!valid_out) check_val({tag, ".squash"}, 128'(ctrl_out), 128'd0);
`ifdef PIPE_PERF_CNT_EN
    check_val({tag, ".stall_cnt"},  128'(stall_cnt),  128'(m_stall_c));
    check_val({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(m_bubble_c));
    check_val({tag, ".issue_cnt"},  128'(issue_cnt),  128'(m_issue_c));
`endif
  endtask

  task automatic set_clr(input logic v);
    m_clr = v;
`ifdef PIPE_PERF_CNT_EN
    cnt_clr = v;
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic rand_payload();
    logic [31:0] r;
    r = $urandom; inst_in = r;
    r = $urandom; ctrl_in = r[CW-1:0];
    r = $urandom; rsel_in = r[RW-1:0];
    data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    inst_in = '0; ctrl_in = '0; data_in = '0; rsel_in = '0;
    set_clr(1'b0);
    model_reset();
    #1;
    compare_all("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    compare_all("rst_hold");

    // Load
    valid_in = 1'b1; inst_in = 32'h0C22_0005; ctrl_in = 16'h0101;
    data_in = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888}; rsel_in = 15'h1234;
    step("load");
    check_val("load.inst_lit", 128'(inst_out), 128'h0C22_0005);

    // Stall hold with changing inputs
    stall = 1'b1; inst_in = 32'hDEAD_BEEF; ctrl_in = 16'hFFFF; data_in = '1;
    for (int i = 0; i < 3; i++) step("stall");
    check_val("stall.inst_lit", 128'(inst_out), 128'h0C22_0005);

    // Flush while stalled
    flush = 1'b1;
    step("flush_stall");
    check_val("flush.inst_lit", 128'(inst_out), 128'(NOP));
    stall = 1'b0; flush = 1'b0;

    // Load then async reset in the middle of a stall
    inst_in = 32'h0C22_0005; ctrl_in = 16'h0101;
    step("reload");
    stall = 1'b1;
    step("stall2");
    #3; rst = 1'b1; #1;
    model_reset();
    compare_all("async_rst");
    #1; rst = 1'b0; stall = 1'b0;
    step("post_rst_load");

    // Long bubble run saturates bubble_cnt, then clear alongside a bubble
    valid_in = 1'b0;
    for (int i = 0; i < 20; i++) step("bubbles");
    set_clr(1'b1);
    step("clr_bubble");
    set_clr(1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      valid_in = ($urandom_range(0, 9) < 7);
      set_clr($urandom_range(0, 19) == 0);
      rand_payload();
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the SimpleRISC five-stage pipeline. It generalises the fixed-width OF/ALU latch into one reusable block for the IF/OF, OF/ALU, ALU/MA and MA/RW boundaries. Beyond the basic hold-on-stall, it adds a valid bit, flush with NOP-bubble insertion, and control-bit squashing. Optional saturating performance counters report stall, bubble and issued-instruction counts per stage boundary.

## Interface
Parameters:
- DATA_W, 128: width of the datapath payload (A, B, op1, op2 concatenated by the instantiating stage).
- CTRL_W, 16: width of the control payload (aluSignals, isWb, is_Ld, is_St, ...).
- RSEL_W, 15: width of register-specifier payload (rd, RP1, RP2).
- NOP_INST, 32'h6800_0000: instruction word loaded on a bubble (SimpleRISC nop).
- CNT_W, 16: performance counter width.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- stall, in, 1: hold all outputs this cycle.
- flush, in, 1: replace the stage contents with a bubble (branch mispredict / taken branch).
- valid_in, in, 1: upstream stage holds a real instruction.
- inst_in, in, 32: instruction word.
- ctrl_in, in, CTRL_W: control signals.
- data_in, in, DATA_W: operand/datapath payload.
- rsel_in, in, RSEL_W: register specifiers.
- valid_out, out, 1: registered valid.
- inst_out, out, 32: registered instruction.
- ctrl_out, out, CTRL_W: registered control; all zero whenever valid_out = 0.
- data_out, out, DATA_W: registered data.
- rsel_out, out, RSEL_W: registered register specifiers.
- Only with PIPE_PERF_CNT_EN:
  - cnt_clr, in, 1: synchronous clear of all counters.
  - stall_cnt, out, CNT_W: stall count.
  - bubble_cnt, out, CNT_W: bubble count.
  - issue_cnt, out, CNT_W: issued-instruction count.

## Operation
- Each cycle, exactly one action applies, in this priority order:
  1. **Flush** (flush = 1, regardless of stall): load a bubble. valid_out = 0, inst_out = NOP_INST, ctrl_out = 0, rsel_out = 0, data_out = 0.
  2. **Hold** (stall = 1, flush = 0): all outputs keep their current values.
  3. **Load** (valid_in = 1): capture inst_in, ctrl_in, data_in, rsel_in; valid_out = 1.
  4. **Bubble** (valid_in = 0): same values as a flush bubble.
- Invariant: valid_out = 0 implies ctrl_out = 0. Downstream stages never see a write-back, load or store from a bubble.
- Two-state view per stage: EMPTY (valid_out = 0) and FULL (valid_out = 1).
  - EMPTY→FULL on Load.
  - FULL→EMPTY on Flush or Bubble.
  - Hold keeps the current state.
- Counters (macro on), each saturating at 2^CNT_W − 1 with no wrap:
  - stall_cnt: +1 each cycle with stall = 1, flush = 0, valid_out = 1.
  - bubble_cnt: +1 each cycle a bubble is loaded (Flush, or Bubble action).
  - issue_cnt: +1 each Load.
- cnt_clr zeroes all counters on the next edge and takes priority over increments in the same cycle.

## Timing
- Latency: 1 cycle, input to output, on a Load.
- Outputs are registers only; there is no combinational path from any input to any output.
- Reset values: valid_out 0, inst_out NOP_INST, ctrl_out 0, data_out 0, rsel_out 0, all counters 0.
- Reset is asserted asynchronously and deasserted synchronously by the system. Reset mid-stall or mid-flush forces the reset values immediately. The first edge after deassertion performs the normal priority action.
- Simultaneous stall and flush: flush wins, and stall_cnt does not increment.
- A stall held for N cycles keeps the outputs bit-identical for N edges.

## Configuration
- PIPE_PERF_CNT_EN:
  - Defined: cnt_clr, stall_cnt, bubble_cnt, issue_cnt ports and counter logic exist as described.
  - Undefined: those ports and the counter logic are absent; datapath behaviour is identical.

## Test plan
- **Reset:** assert rst mid-cycle with valid_out = 1 → outputs immediately valid_out 0, inst_out 32'h6800_0000, ctrl_out 0; counters 0.
- **Load:** valid_in 1, inst_in 32'h0C22_0005, ctrl_in 16'h0101 → next edge: valid_out 1, inst_out 32'h0C22_0005, ctrl_out 16'h0101; issue_cnt 1.
- **Stall hold:** after the load, stall = 1 for 3 cycles while inst_in changes to 32'hDEAD_BEEF → inst_out stays 32'h0C22_0005 for 3 edges; stall_cnt 3.
- **Flush during stall:** stall = 1 and flush = 1 together → next edge: valid_out 0, inst_out 32'h6800_0000, ctrl_out 0; bubble_cnt +1, stall_cnt unchanged.
- **Saturation and clear:** CNT_W = 4, valid_in = 0 for 20 cycles → bubble_cnt holds at 15; then cnt_clr together with a bubble → bubble_cnt 0.
- **Macro off:** compile without PIPE_PERF_CNT_EN and rerun the load, stall and flush scenarios → identical datapath outputs; counter ports do not exist.
